// File: rtl/reorder_buffer_pkg.sv
// Shared ROB/rename definitions: sizes, allocate-word field positions and
// the reset image of the committed RAT.
package rob_pkg;

  localparam int unsigned ROB_SIZE       = 64;
  localparam int unsigned ROB_ENTRY_SIZE = 192;
  localparam int unsigned RAT_SIZE       = 32;
  localparam int unsigned RAT_ENTRY_SIZE = 7;

  localparam int unsigned ROB_IDX_W = 6;
  localparam int unsigned ARC_W     = 5;
  localparam int unsigned PHY_W     = 6;

  localparam int unsigned ENT_WB_BIT  = 140;
  localparam int unsigned ENT_ARC_LSB = 106;
  localparam int unsigned ENT_PHY_LSB = 174;

  typedef logic [ROB_IDX_W-1:0]      rob_idx_t;
  typedef logic [ARC_W-1:0]          arc_t;
  typedef logic [PHY_W-1:0]          phy_t;
  typedef logic [RAT_ENTRY_SIZE-1:0] rat_entry_t;

  localparam rat_entry_t RAT_RST_R29 = 7'h7E;
  localparam rat_entry_t RAT_RST_R31 = 7'h7F;

  typedef struct packed {
    logic wb;
    arc_t arc;
    phy_t phy;
  } rob_payload_t;

  function automatic rat_entry_t rat_reset_value(input int unsigned idx);
    if (idx == 29) return RAT_RST_R29;
    if (idx == 31) return RAT_RST_R31;
    return '0;
  endfunction

endpackage

// File: rtl/reorder_buffer_if.sv
// Rename/execute <-> ROB signal bundle; the ROB sits on the slave side.
interface reorder_buffer_if;
  import rob_pkg::*;

  logic                                   FREEZE;
  logic                                   do_write_2ROB;
  logic [ROB_ENTRY_SIZE-1:0]              ROB_entry;
  logic                                   do_complete;
  rob_idx_t                               complete_index;
  logic                                   complete_mispredict;
  logic                                   full_ROB;
  rob_idx_t                               ROB_head;
  rob_idx_t                               ROB_tail;
  rob_idx_t                               reg_counter;
  logic                                   do_reclaim;
  phy_t                                   reclaimed_reg;
  logic                                   flush_fCOM;
  logic                                   do_copy_RAT;
  rat_entry_t [RAT_SIZE-1:0]              old_RAT;

  modport master (
    output FREEZE, do_write_2ROB, ROB_entry, do_complete, complete_index,
           complete_mispredict,
    input  full_ROB, ROB_head, ROB_tail, reg_counter, do_reclaim,
           reclaimed_reg, flush_fCOM, do_copy_RAT, old_RAT
  );

  modport slave (
    input  FREEZE, do_write_2ROB, ROB_entry, do_complete, complete_index,
           complete_mispredict,
    output full_ROB, ROB_head, ROB_tail, reg_counter, do_reclaim,
           reclaimed_reg, flush_fCOM, do_copy_RAT, old_RAT
  );
endinterface

// File: rtl/reorder_buffer_commit_rat.sv
// Committed (architectural) RAT: one write port, one combinational read port,
// whole array also exported for the rename-stage restore copy.
module commit_rat
  import rob_pkg::*;
#(
  parameter int unsigned DEPTH = RAT_SIZE
) (
  input  logic                   clk_i,
  input  logic                   rst_i,
  input  logic                   we_i,
  input  arc_t                   waddr_i,
  input  rat_entry_t             wdata_i,
  input  arc_t                   raddr_i,
  output rat_entry_t             rdata_o,
  output rat_entry_t [DEPTH-1:0] rat_o
);

  rat_entry_t [DEPTH-1:0] rat_q;

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      for (int unsigned i = 0; i < DEPTH; i++) begin
        rat_q[ARC_W'(i)] <= rat_reset_value(i);
      end
    end else if (we_i) begin
      rat_q[waddr_i] <= wdata_i;
    end
  end

  assign rdata_o = rat_q[raddr_i];
  assign rat_o   = rat_q;

endmodule

// File: rtl/reorder_buffer.sv
// In-order retirement buffer: allocate at tail, out-of-order completion,
// single-entry commit at head with RAT update, reclaim and mispredict flush.
module reorder_buffer #(
  parameter int unsigned ROB_SIZE       = rob_pkg::ROB_SIZE,
  parameter int unsigned ROB_ENTRY_SIZE = rob_pkg::ROB_ENTRY_SIZE,
  parameter int unsigned RAT_SIZE       = rob_pkg::RAT_SIZE,
  parameter int unsigned RAT_ENTRY_SIZE = rob_pkg::RAT_ENTRY_SIZE
) (
  input logic             CLK,
  input logic             RESET,
  reorder_buffer_if.slave bus
);

  localparam int unsigned IDX_W = $clog2(ROB_SIZE);
  localparam int unsigned CNT_W = IDX_W + 1;

  typedef logic [IDX_W-1:0]          idx_t;
  typedef logic [CNT_W-1:0]          cnt_t;
  typedef logic [RAT_ENTRY_SIZE-1:0] rat_word_t;

  logic [ROB_SIZE-1:0] valid_q, done_q, misp_q, wb_q;
  rob_pkg::arc_t       arc_q [ROB_SIZE];
  rob_pkg::phy_t       phy_q [ROB_SIZE];

  idx_t          head_q, head_d, tail_q, tail_d;
  idx_t          reg_counter_q, reg_counter_d;
  cnt_t          count_q, count_d, wb_count_q, wb_count_d;
  logic          do_reclaim_q, do_reclaim_d;
  rob_pkg::phy_t reclaimed_q, reclaimed_d;
  logic          flush_q, flush_d;
  logic          copy_q, copy_d;

  logic [ROB_ENTRY_SIZE-1:0] alloc_word;
  logic                      unused_entry_parity;
  rob_pkg::rob_payload_t     alloc_pl;

  logic      full, alloc_en, cmp_en, commit_en, commit_wb, commit_flush;
  rat_word_t rat_rd, rat_wdata;

  assign alloc_word          = bus.ROB_entry;
  assign unused_entry_parity = ^alloc_word;
  assign alloc_pl.wb  = alloc_word[rob_pkg::ENT_WB_BIT];
  assign alloc_pl.arc = alloc_word[rob_pkg::ENT_ARC_LSB +: rob_pkg::ARC_W];
  assign alloc_pl.phy = alloc_word[rob_pkg::ENT_PHY_LSB +: rob_pkg::PHY_W];

  assign full         = (count_q == cnt_t'(ROB_SIZE));
  assign alloc_en     = bus.do_write_2ROB & ~full & ~bus.FREEZE & ~flush_q;
  assign cmp_en       = bus.do_complete & ~bus.FREEZE & valid_q[bus.complete_index];
  // done_q is registered, so an entry completed on this edge commits no earlier than the next
  assign commit_en    = valid_q[head_q] & done_q[head_q] & ~bus.FREEZE;
  assign commit_wb    = commit_en & wb_q[head_q];
  assign commit_flush = commit_en & misp_q[head_q];
  assign rat_wdata    = {1'b1, phy_q[head_q]};

  commit_rat #(
    .DEPTH (RAT_SIZE)
  ) u_commit_rat (
    .clk_i   (CLK),
    .rst_i   (RESET),
    .we_i    (commit_wb),
    .waddr_i (arc_q[head_q]),
    .wdata_i (rat_wdata),
    .raddr_i (arc_q[head_q]),
    .rdata_o (rat_rd),
    .rat_o   (bus.old_RAT)
  );

  always_comb begin
    head_d        = head_q + idx_t'(commit_en);
    tail_d        = tail_q + idx_t'(alloc_en);
    count_d       = count_q + cnt_t'(alloc_en) - cnt_t'(commit_en);
    wb_count_d    = wb_count_q + cnt_t'(alloc_en & alloc_pl.wb) - cnt_t'(commit_wb);
    reg_counter_d = reg_counter_q;
    if (commit_flush) begin
      tail_d        = head_q + idx_t'(1);
      count_d       = '0;
      wb_count_d    = '0;
      reg_counter_d = idx_t'(wb_count_q - cnt_t'(wb_q[head_q]));
    end
    do_reclaim_d = commit_wb & rat_rd[RAT_ENTRY_SIZE-1];
    reclaimed_d  = do_reclaim_d ? rat_rd[rob_pkg::PHY_W-1:0] : reclaimed_q;
    flush_d      = commit_flush;
    copy_d       = commit_flush;
  end

  always_ff @(posedge CLK) begin
    if (RESET) begin
      head_q        <= '0;
      tail_q        <= '0;
      count_q       <= '0;
      wb_count_q    <= '0;
      reg_counter_q <= '0;
      do_reclaim_q  <= 1'b0;
      reclaimed_q   <= '0;
      flush_q       <= 1'b0;
      copy_q        <= 1'b0;
    end else begin
      head_q        <= head_d;
      tail_q        <= tail_d;
      count_q       <= count_d;
      wb_count_q    <= wb_count_d;
      reg_counter_q <= reg_counter_d;
      do_reclaim_q  <= do_reclaim_d;
      reclaimed_q   <= reclaimed_d;
      flush_q       <= flush_d;
      copy_q        <= copy_d;
    end
  end

  // Later assignments win: commit clears override a same-cycle complete,
  // and a flush wipes everything including a same-cycle allocate.
  always_ff @(posedge CLK) begin
    if (RESET) begin
      valid_q <= '0;
      done_q  <= '0;
      misp_q  <= '0;
    end else begin
      if (alloc_en) begin
        valid_q[tail_q] <= 1'b1;
        done_q[tail_q]  <= 1'b0;
        misp_q[tail_q]  <= 1'b0;
      end
      if (cmp_en) begin
        done_q[bus.complete_index] <= 1'b1;
        misp_q[bus.complete_index] <= bus.complete_mispredict;
      end
      if (commit_en) begin
        valid_q[head_q] <= 1'b0;
        done_q[head_q]  <= 1'b0;
        misp_q[head_q]  <= 1'b0;
      end
      if (commit_flush) begin
        valid_q <= '0;
        done_q  <= '0;
        misp_q  <= '0;
      end
    end
  end

  always_ff @(posedge CLK) begin
    if (alloc_en) begin
      wb_q[tail_q]  <= alloc_pl.wb;
      arc_q[tail_q] <= alloc_pl.arc;
      phy_q[tail_q] <= alloc_pl.phy;
    end
  end

  assign bus.full_ROB      = full;
  assign bus.ROB_head      = head_q;
  assign bus.ROB_tail      = tail_q;
  assign bus.reg_counter   = reg_counter_q;
  assign bus.do_reclaim    = do_reclaim_q;
  assign bus.reclaimed_reg = reclaimed_q;
  assign bus.flush_fCOM    = flush_q;
  assign bus.do_copy_RAT   = copy_q;

endmodule
